// File: rtl/pac_mport.sv
// pac_mport: packet action/dispatch stage.
// Applies the per-packet action carried with the head beat, replicates each
// beat to the switch path and to a subset of direct ports with one cycle of
// latency, gates switch-path admission on per-priority free-buffer thresholds,
// builds TSN metadata and keeps packet-out / drop / error counters.
// Optional feature: define PAC_PING_CNT_EN to add the 16-bit ping_cnt output.
//
// state | meaning
// IDLE  | waiting for a head beat; middle/tail beats are ignored
// TRANS | packet in progress, beats forwarded per reg_dest
// DISC  | packet in progress with no destination, beats discarded
module pac_mport #(
    parameter int PORT_NUM = 4,
    parameter int ID_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [133:0]          in_pac_data,
    input  logic                  in_pac_data_wr,
    input  logic [PORT_NUM+4:0]   in_pac_action,
    input  logic                  in_pac_action_wr,
    input  logic [ID_W-1:0]       bufm_ID_count,
    input  logic [8*ID_W-1:0]     cfg_thr,
    output logic [133:0]          out_pac_data,
    output logic                  out_pac_data_wr,
    output logic                  out_pac_valid,
    output logic                  out_pac_valid_wr,
    output logic [23:0]           out_pac_tsn_md,
    output logic                  out_pac_tsn_md_wr,
    output logic [133:0]          out_port_data,
    output logic [PORT_NUM-1:0]   out_port_data_wr,
    output logic [PORT_NUM-1:0]   out_port_valid_wr,
    output logic [63:0]           pktout_cnt,
    output logic [31:0]           drop_cnt,
    output logic [15:0]           err_cnt,
`ifdef PAC_PING_CNT_EN
    output logic [15:0]           ping_cnt,
`endif
    output logic [7:0]            bufm_ID_cnt
);

    typedef enum logic [1:0] {IDLE, TRANS, DISC} state_t;

    state_t              state, state_nxt;
    logic [PORT_NUM:0]   reg_dest, dest_nxt;
    logic [PORT_NUM:0]   cur_dest;
    logic [PORT_NUM:0]   new_dest;
    logic [PORT_NUM+4:0] act;
    logic [2:0]          act_pri;
    logic                act_sw;
    logic [PORT_NUM-1:0] act_map;
    logic                act_tsn;
    logic [ID_W-1:0]     thr_sel;
    logic                admit_sw;
    logic                is_head, is_mid, is_tail;
    logic                fwd_tail;
    logic                drop_inc, err_inc;

    assign bufm_ID_cnt = 8'(bufm_ID_count);

    // Decode the beat tag and the action presented with a head beat
    always_comb begin
        is_head  = in_pac_data_wr && (in_pac_data[133:132] == 2'b01);
        is_mid   = in_pac_data_wr && (in_pac_data[133:132] == 2'b11);
        is_tail  = in_pac_data_wr && (in_pac_data[133:132] == 2'b10);
        act      = in_pac_action_wr ? in_pac_action : '0;
        act_tsn  = act[0];
        act_map  = act[PORT_NUM:1];
        act_sw   = act[PORT_NUM+1];
        act_pri  = act[PORT_NUM+4:PORT_NUM+2];
        thr_sel  = cfg_thr[act_pri*ID_W +: ID_W];
        admit_sw = act_sw && (bufm_ID_count > thr_sel);
        new_dest = {admit_sw, act_map};
        drop_inc = is_head && ((new_dest == '0) || (act_sw && !admit_sw));
        err_inc  = is_head && (state != IDLE);
    end

    // State register and latched destination set
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            reg_dest <= '0;
        end else begin
            state    <= state_nxt;
            reg_dest <= dest_nxt;
        end
    end

    // Next state and the destination set applied to the current beat
    always_comb begin
        state_nxt = state;
        dest_nxt  = reg_dest;
        cur_dest  = '0;
        fwd_tail  = 1'b0;
        if (is_head) begin
            // A head always starts a new packet, even mid-packet.
            cur_dest  = new_dest;
            dest_nxt  = new_dest;
            state_nxt = (new_dest == '0) ? DISC : TRANS;
        end else if ((is_mid || is_tail) && (state != IDLE)) begin
            cur_dest = reg_dest;
            if (is_tail) begin
                fwd_tail  = 1'b1;
                state_nxt = IDLE;
            end
        end
    end

    // Registered beat fan-out; buses return to zero when nothing is written
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_pac_data      <= '0;
            out_pac_data_wr   <= 1'b0;
            out_pac_valid     <= 1'b0;
            out_pac_valid_wr  <= 1'b0;
            out_pac_tsn_md    <= '0;
            out_pac_tsn_md_wr <= 1'b0;
            out_port_data     <= '0;
            out_port_data_wr  <= '0;
            out_port_valid_wr <= '0;
        end else begin
            out_pac_data      <= cur_dest[PORT_NUM] ? in_pac_data : '0;
            out_pac_data_wr   <= cur_dest[PORT_NUM];
            out_pac_valid     <= fwd_tail && cur_dest[PORT_NUM];
            out_pac_valid_wr  <= fwd_tail && cur_dest[PORT_NUM];
            out_pac_tsn_md    <= (is_head && admit_sw) ?
                                 {act_pri, in_pac_data[107:96], act_tsn, 8'h00} : '0;
            out_pac_tsn_md_wr <= is_head && admit_sw;
            out_port_data     <= (|cur_dest[PORT_NUM-1:0]) ? in_pac_data : '0;
            out_port_data_wr  <= cur_dest[PORT_NUM-1:0];
            out_port_valid_wr <= fwd_tail ? cur_dest[PORT_NUM-1:0] : '0;
        end
    end

    // Statistics counters: packets out and drops wrap, errors saturate
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pktout_cnt <= '0;
            drop_cnt   <= '0;
            err_cnt    <= '0;
        end else begin
            if (fwd_tail && (cur_dest != '0))
                pktout_cnt <= pktout_cnt + 64'd1;
            if (drop_inc)
                drop_cnt <= drop_cnt + 32'd1;
            if (err_inc && (err_cnt != 16'hffff))
                err_cnt <= err_cnt + 16'd1;
        end
    end

`ifdef PAC_PING_CNT_EN
    // Count ping heads that reach at least one direct port
    always_ff @(posedge clk) begin
        if (!rst_n)
            ping_cnt <= '0;
        else if (is_head && (|act_map) && (in_pac_data[79:72] == 8'hff))
            ping_cnt <= ping_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_pac_mport.sv
// Directed bench for pac_mport with hand-computed expectations.
module tb_pac_mport;
    localparam int PN = 4;
    localparam int IW = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [133:0]   in_pac_data;
    logic           in_pac_data_wr;
    logic [PN+4:0]  in_pac_action;
    logic           in_pac_action_wr;
    logic [IW-1:0]  bufm_ID_count;
    logic [8*IW-1:0] cfg_thr;
    logic [133:0]   out_pac_data;
    logic           out_pac_data_wr;
    logic           out_pac_valid;
    logic           out_pac_valid_wr;
    logic [23:0]    out_pac_tsn_md;
    logic           out_pac_tsn_md_wr;
    logic [133:0]   out_port_data;
    logic [PN-1:0]  out_port_data_wr;
    logic [PN-1:0]  out_port_valid_wr;
    logic [63:0]    pktout_cnt;
    logic [31:0]    drop_cnt;
    logic [15:0]    err_cnt;
`ifdef PAC_PING_CNT_EN
    logic [15:0]    ping_cnt;
`endif
    logic [7:0]     bufm_ID_cnt;

    int n_chk = 0;
    int n_err = 0;
    int seq   = 0;
    logic [133:0] last_d;

    pac_mport #(.PORT_NUM(PN), .ID_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_pac_data(in_pac_data), .in_pac_data_wr(in_pac_data_wr),
        .in_pac_action(in_pac_action), .in_pac_action_wr(in_pac_action_wr),
        .bufm_ID_count(bufm_ID_count), .cfg_thr(cfg_thr),
        .out_pac_data(out_pac_data), .out_pac_data_wr(out_pac_data_wr),
        .out_pac_valid(out_pac_valid), .out_pac_valid_wr(out_pac_valid_wr),
        .out_pac_tsn_md(out_pac_tsn_md), .out_pac_tsn_md_wr(out_pac_tsn_md_wr),
        .out_port_data(out_port_data), .out_port_data_wr(out_port_data_wr),
        .out_port_valid_wr(out_port_valid_wr),
        .pktout_cnt(pktout_cnt), .drop_cnt(drop_cnt), .err_cnt(err_cnt),
`ifdef PAC_PING_CNT_EN
        .ping_cnt(ping_cnt),
`endif
        .bufm_ID_cnt(bufm_ID_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [133:0] got, input logic [133:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [PN+4:0] mk(input logic [2:0] p, input logic s,
                                         input logic [PN-1:0] m, input logic f);
        return {p, s, m, f};
    endfunction

    // Drive one beat at the falling edge; return 1 ns after the capturing edge.
    task automatic beat(input logic [1:0] t, input logic awr, input logic [PN+4:0] a);
        logic [133:0] d;
        @(negedge clk);
        seq++;
        d = '0;
        d[133:132] = t;
        d[107:96]  = 12'hABC;
        d[79:72]   = 8'hff;
        d[31:0]    = 32'(seq);
        last_d           = d;
        in_pac_data      = d;
        in_pac_data_wr   = 1'b1;
        in_pac_action    = awr ? a : '0;
        in_pac_action_wr = awr;
        @(posedge clk);
        #1;
        in_pac_data      = '0;
        in_pac_data_wr   = 1'b0;
        in_pac_action    = '0;
        in_pac_action_wr = 1'b0;
    endtask

    task automatic gap();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_out(input string tag, input logic sw, input logic [PN-1:0] pm,
                           input logic md, input logic sv, input logic [PN-1:0] pv);
        chk({tag, "_sw_wr"},   out_pac_data_wr, sw);
        chk({tag, "_sw_data"}, out_pac_data, sw ? last_d : '0);
        chk({tag, "_pt_wr"},   out_port_data_wr, pm);
        chk({tag, "_pt_data"}, out_port_data, (pm != '0) ? last_d : '0);
        chk({tag, "_md_wr"},   out_pac_tsn_md_wr, md);
        chk({tag, "_sv_wr"},   out_pac_valid_wr, sv);
        chk({tag, "_pv_wr"},   out_port_valid_wr, pv);
    endtask

    initial begin
        rst_n = 1'b0;
        in_pac_data = '0;
        in_pac_data_wr = 1'b0;
        in_pac_action = '0;
        in_pac_action_wr = 1'b0;
        bufm_ID_count = 5'd10;
        cfg_thr = '0;
        for (int p = 0; p < 8; p++) cfg_thr[p*IW +: IW] = 5'(p);
        cfg_thr[5*IW +: IW] = 5'd3;
        last_d = '0;
        repeat (2) @(posedge clk);
        #1;
        exp_out("rst", 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        chk("rst_pkt", pktout_cnt, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_md", out_pac_tsn_md, 0);
        chk("idcnt", bufm_ID_cnt, 8'd10);
        rst_n = 1'b1;

        // T1: admitted to switch and ports 0,2, with an input gap
        beat(2'b01, 1'b1, mk(3'd5, 1'b1, 4'b0101, 1'b1));
        exp_out("t1_head", 1'b1, 4'b0101, 1'b1, 1'b0, 4'b0000);
        chk("t1_md", out_pac_tsn_md, {3'd5, 12'hABC, 1'b1, 8'h00});
        beat(2'b11, 1'b0, '0);
        exp_out("t1_mid", 1'b1, 4'b0101, 1'b0, 1'b0, 4'b0000);
        gap();
        exp_out("t1_gap", 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        beat(2'b11, 1'b0, '0);
        exp_out("t1_mid2", 1'b1, 4'b0101, 1'b0, 1'b0, 4'b0000);
        beat(2'b10, 1'b0, '0);
        exp_out("t1_tail", 1'b1, 4'b0101, 1'b0, 1'b1, 4'b0101);
        chk("t1_valid", out_pac_valid, 1'b1);
        chk("t1_pkt", pktout_cnt, 1);
        chk("t1_drop", drop_cnt, 0);

        // T2: count equals threshold -> switch refused, ports still served
        bufm_ID_count = 5'd3;
        beat(2'b01, 1'b1, mk(3'd5, 1'b1, 4'b0101, 1'b1));
        exp_out("t2_head", 1'b0, 4'b0101, 1'b0, 1'b0, 4'b0000);
        chk("t2_drop", drop_cnt, 1);
        beat(2'b10, 1'b0, '0);
        exp_out("t2_tail", 1'b0, 4'b0101, 1'b0, 1'b0, 4'b0101);
        chk("t2_pkt", pktout_cnt, 2);

        // T3: no destination at all -> discarded, then normal packet
        bufm_ID_count = 5'd0;
        beat(2'b01, 1'b1, mk(3'd5, 1'b1, 4'b0000, 1'b0));
        exp_out("t3_head", 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        beat(2'b11, 1'b0, '0);
        exp_out("t3_mid", 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        beat(2'b10, 1'b0, '0);
        exp_out("t3_tail", 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        chk("t3_drop", drop_cnt, 2);
        chk("t3_pkt", pktout_cnt, 2);
        bufm_ID_count = 5'd10;
        beat(2'b01, 1'b1, mk(3'd5, 1'b1, 4'b0101, 1'b1));
        exp_out("t3b_head", 1'b1, 4'b0101, 1'b1, 1'b0, 4'b0000);
        beat(2'b10, 1'b0, '0);
        exp_out("t3b_tail", 1'b1, 4'b0101, 1'b0, 1'b1, 4'b0101);
        chk("t3b_pkt", pktout_cnt, 3);

        // T4: head inside a packet; count one above threshold admits
        bufm_ID_count = 5'd4;
        beat(2'b01, 1'b1, mk(3'd5, 1'b0, 4'b0001, 1'b0));
        exp_out("t4_headA", 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0000);
        beat(2'b11, 1'b0, '0);
        exp_out("t4_mid", 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0000);
        beat(2'b01, 1'b1, mk(3'd5, 1'b1, 4'b0010, 1'b0));
        exp_out("t4_headB", 1'b1, 4'b0010, 1'b1, 1'b0, 4'b0000);
        chk("t4_md", out_pac_tsn_md, {3'd5, 12'hABC, 1'b0, 8'h00});
        chk("t4_err", err_cnt, 1);
        beat(2'b10, 1'b0, '0);
        exp_out("t4_tail", 1'b1, 4'b0010, 1'b0, 1'b1, 4'b0010);
        chk("t4_pkt", pktout_cnt, 4);
        chk("t4_drop", drop_cnt, 2);

        // T5: reset on beat 2 of a 5-beat packet
        beat(2'b01, 1'b1, mk(3'd5, 1'b0, 4'b0011, 1'b0));
        exp_out("t5_head", 1'b0, 4'b0011, 1'b0, 1'b0, 4'b0000);
        rst_n = 1'b0;
        beat(2'b11, 1'b0, '0);
        exp_out("t5_rst", 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        chk("t5_rst_pkt", pktout_cnt, 0);
        chk("t5_rst_err", err_cnt, 0);
        chk("t5_rst_drop", drop_cnt, 0);
        rst_n = 1'b1;
        beat(2'b11, 1'b0, '0);
        exp_out("t5_b3", 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        beat(2'b11, 1'b0, '0);
        exp_out("t5_b4", 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        beat(2'b10, 1'b0, '0);
        exp_out("t5_b5", 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        chk("t5_pkt0", pktout_cnt, 0);
        beat(2'b01, 1'b1, mk(3'd5, 1'b0, 4'b0100, 1'b0));
        exp_out("t5n_head", 1'b0, 4'b0100, 1'b0, 1'b0, 4'b0000);
        beat(2'b10, 1'b0, '0);
        exp_out("t5n_tail", 1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100);
        chk("t5n_pkt", pktout_cnt, 1);
        chk("t5n_err", err_cnt, 0);
`ifdef PAC_PING_CNT_EN
        chk("ping_port", ping_cnt, 1);
`endif

        // Switch-only packet: no ports, ping count untouched
        beat(2'b01, 1'b1, mk(3'd5, 1'b1, 4'b0000, 1'b0));
        exp_out("sw_head", 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000);
        beat(2'b10, 1'b0, '0);
        exp_out("sw_tail", 1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000);
        chk("sw_pkt", pktout_cnt, 2);
        chk("sw_drop", drop_cnt, 0);
`ifdef PAC_PING_CNT_EN
        chk("ping_sw", ping_cnt, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
